hazard_ctrl: RTL and testbench

- Hazard detection and forwarding controller for the 5-stage RV32I pipeline.
- Keeps its own scoreboard of the destination registers for the instructions in EX and MEM.
- Computes the six forwarding selects for the instruction entering EX, and registers them so the EX-stage operand mux sees stable selects.
- Generates the load-use stall/bubble and handles control-flow flushes and external memory stalls.

---
 rtl/hazard_ctrl.sv | 110 +++++++++++
 tb/tb_hazard_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard detection and forwarding controller for a 5-stage RV32I pipeline.
// Tracks rd of the EX/MEM instructions, registers EX-stage forwarding selects, raises load-use stalls.
module hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_use_rs1,
  input  logic              i_id_use_rs2,
  input  logic [REG_AW-1:0] i_id_rd,
  input  logic              i_id_wen,
  input  logic              i_id_load,
  input  logic              i_flush,
  input  logic              i_mem_stall,
  output logic              o_stall,
  output logic              o_bubble,
  output logic              o_frwd_alu_op1,
  output logic              o_frwd_mem_alu_op1,
  output logic              o_frwd_mem_op1,
  output logic              o_frwd_alu_op2,
  output logic              o_frwd_mem_alu_op2,
  output logic              o_frwd_mem_op2,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              wen;
    logic              load;
  } slot_t;

  slot_t            ex_q, ex_d, mem_q;
  logic [2:0]       op1_sel_q, op1_sel_d, op2_sel_q, op2_sel_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic ex_hit1, ex_hit2, mem_hit1, mem_hit2, load_use, kill;

  function automatic logic slot_hit(input slot_t s, input logic [REG_AW-1:0] src,
                                    input logic use_src);
    return s.valid && s.wen && use_src && (src != '0) && (s.rd == src);
  endfunction

  // Select encoding per operand: {from EX ALU, from MEM ALU, from MEM read data}.
  function automatic logic [2:0] pick_sel(input logic d1, input logic d1_load,
                                          input logic d2, input logic d2_load);
    logic [2:0] sel;
    sel = 3'b000;
    if (d1 && !d1_load)       sel = 3'b100;
    else if (!d1 && d2)       sel = d2_load ? 3'b001 : 3'b010;
    return sel;
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    ex_hit1  = slot_hit(ex_q,  i_id_rs1, i_id_use_rs1);
    ex_hit2  = slot_hit(ex_q,  i_id_rs2, i_id_use_rs2);
    mem_hit1 = slot_hit(mem_q, i_id_rs1, i_id_use_rs1);
    mem_hit2 = slot_hit(mem_q, i_id_rs2, i_id_use_rs2);

    load_use = i_id_valid && ex_q.load && (ex_hit1 || ex_hit2);
    o_bubble = load_use && !i_flush && !i_mem_stall;
    o_stall  = i_mem_stall || (load_use && !i_flush);
    kill     = o_bubble || i_flush;

    ex_d       = '0;
    op1_sel_d  = '0;
    op2_sel_d  = '0;
    if (!kill) begin
      ex_d.valid = i_id_valid;
      ex_d.rd    = i_id_rd;
      ex_d.wen   = i_id_wen;
      ex_d.load  = i_id_load;
      if (i_id_valid) begin
        op1_sel_d = pick_sel(ex_hit1, ex_q.load, mem_hit1, mem_q.load);
        op2_sel_d = pick_sel(ex_hit2, ex_q.load, mem_hit2, mem_q.load);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      op1_sel_q   <= '0;
      op2_sel_q   <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (!i_mem_stall) begin
      mem_q     <= ex_q;
      ex_q      <= ex_d;
      op1_sel_q <= op1_sel_d;
      op2_sel_q <= op2_sel_d;
      if (o_bubble && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (i_flush  && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign {o_frwd_alu_op1, o_frwd_mem_alu_op1, o_frwd_mem_op1} = op1_sel_q;
  assign {o_frwd_alu_op2, o_frwd_mem_alu_op2, o_frwd_mem_op2} = op2_sel_q;
  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: forwarding, load-use, flush, freeze and reset cases.
module tb_hazard_ctrl;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 16;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic              i_id_valid;
  logic [REG_AW-1:0] i_id_rs1, i_id_rs2, i_id_rd;
  logic              i_id_use_rs1, i_id_use_rs2, i_id_wen, i_id_load;
  logic              i_flush, i_mem_stall;
  logic              o_stall, o_bubble;
  logic              o_frwd_alu_op1, o_frwd_mem_alu_op1, o_frwd_mem_op1;
  logic              o_frwd_alu_op2, o_frwd_mem_alu_op2, o_frwd_mem_op2;
  logic [CNT_W-1:0]  o_stall_cnt, o_flush_cnt;
  logic [5:0]        sel;

  int checks   = 0;
  int failures = 0;

  hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .i_id_valid         (i_id_valid),
    .i_id_rs1           (i_id_rs1),
    .i_id_rs2           (i_id_rs2),
    .i_id_use_rs1       (i_id_use_rs1),
    .i_id_use_rs2       (i_id_use_rs2),
    .i_id_rd            (i_id_rd),
    .i_id_wen           (i_id_wen),
    .i_id_load          (i_id_load),
    .i_flush            (i_flush),
    .i_mem_stall        (i_mem_stall),
    .o_stall            (o_stall),
    .o_bubble           (o_bubble),
    .o_frwd_alu_op1     (o_frwd_alu_op1),
    .o_frwd_mem_alu_op1 (o_frwd_mem_alu_op1),
    .o_frwd_mem_op1     (o_frwd_mem_op1),
    .o_frwd_alu_op2     (o_frwd_alu_op2),
    .o_frwd_mem_alu_op2 (o_frwd_mem_alu_op2),
    .o_frwd_mem_op2     (o_frwd_mem_op2),
    .o_stall_cnt        (o_stall_cnt),
    .o_flush_cnt        (o_flush_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Selects packed as {alu1, mem_alu1, mem1, alu2, mem_alu2, mem2}.
  assign sel = {o_frwd_alu_op1, o_frwd_mem_alu_op1, o_frwd_mem_op1,
                o_frwd_alu_op2, o_frwd_mem_alu_op2, o_frwd_mem_op2};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic id(input int rs1, input int rs2, input logic u1, input logic u2,
                    input int rd, input logic wen, input logic load);
    i_id_valid   = 1'b1;
    i_id_rs1     = REG_AW'(rs1);
    i_id_rs2     = REG_AW'(rs2);
    i_id_use_rs1 = u1;
    i_id_use_rs2 = u2;
    i_id_rd      = REG_AW'(rd);
    i_id_wen     = wen;
    i_id_load    = load;
    #1;
  endtask

  task automatic nop();
    i_id_valid   = 1'b0;
    i_id_rs1     = '0;
    i_id_rs2     = '0;
    i_id_use_rs1 = 1'b0;
    i_id_use_rs2 = 1'b0;
    i_id_rd      = '0;
    i_id_wen     = 1'b0;
    i_id_load    = 1'b0;
    #1;
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_flush = 1'b0;
    i_mem_stall = 1'b0;
    nop();
    #20;
    check("rst_stall", o_stall, 0);
    check("rst_bubble", o_bubble, 0);
    check("rst_sel", sel, 0);
    check("rst_stall_cnt", o_stall_cnt, 0);
    check("rst_flush_cnt", o_flush_cnt, 0);
    tick();
    i_rst_n = 1'b1;

    // add x5,x1,x2 ; add x6,x5,x1
    id(1, 2, 1, 1, 5, 1, 0);
    check("add1_stall", o_stall, 0);
    tick();
    id(5, 1, 1, 1, 6, 1, 0);
    check("add2_stall", o_stall, 0);
    tick();
    check("d1_alu_op1", sel, 6'b100000);

    // lw x7 ; nop ; sub x8,x1,x7
    id(1, 0, 1, 0, 7, 1, 1);
    tick();
    nop();
    tick();
    id(1, 7, 1, 1, 8, 1, 0);
    check("sub_stall", o_stall, 0);
    tick();
    check("d2_mem_op2", sel, 6'b000001);

    // add x7 ; nop ; sub x8,x1,x7
    id(1, 2, 1, 1, 7, 1, 0);
    tick();
    nop();
    tick();
    id(1, 7, 1, 1, 8, 1, 0);
    tick();
    check("d2_mem_alu_op2", sel, 6'b000010);

    // lw x9 ; or x10,x9,x9 -> single bubble
    id(1, 0, 1, 0, 9, 1, 1);
    tick();
    id(9, 9, 1, 1, 10, 1, 0);
    check("lu_stall", o_stall, 1);
    check("lu_bubble", o_bubble, 1);
    check("lu_cnt_before", o_stall_cnt, 0);
    tick();
    check("lu_retry_stall", o_stall, 0);
    check("lu_retry_bubble", o_bubble, 0);
    check("lu_cnt_after", o_stall_cnt, 1);
    check("lu_bubble_sel", sel, 0);
    tick();
    check("lu_mem_both", sel, 6'b001001);

    // x0 producer and consumer
    id(1, 2, 1, 1, 0, 1, 0);
    tick();
    id(0, 0, 1, 1, 11, 1, 0);
    check("x0_stall", o_stall, 0);
    tick();
    check("x0_sel", sel, 0);
    // rs2 field matches but rs2 unused
    id(1, 11, 1, 0, 12, 1, 0);
    tick();
    check("unused_rs2_sel", sel, 0);
    id(2, 3, 1, 0, 13, 1, 1);
    tick();
    id(1, 13, 1, 0, 14, 1, 0);
    check("unused_rs2_lu_stall", o_stall, 0);
    check("unused_rs2_lu_bubble", o_bubble, 0);
    tick();
    check("unused_rs2_lu_sel", sel, 0);

    // lw x3 in MEM, add x3 in EX, consumer of x3
    id(1, 0, 1, 0, 3, 1, 1);
    tick();
    id(1, 2, 1, 1, 3, 1, 0);
    tick();
    id(3, 0, 1, 0, 15, 1, 0);
    check("prio_stall", o_stall, 0);
    tick();
    check("prio_alu_op1", sel, 6'b100000);

    // Memory stall held over a load-use: everything frozen
    id(15, 0, 1, 0, 9, 1, 1);
    tick();
    check("pre_freeze_sel", sel, 6'b100000);
    id(9, 0, 1, 0, 16, 1, 0);
    check("pre_freeze_bubble", o_bubble, 1);
    i_mem_stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("freeze_stall", o_stall, 1);
      check("freeze_bubble", o_bubble, 0);
      tick();
      check("freeze_sel", sel, 6'b100000);
      check("freeze_stall_cnt", o_stall_cnt, 1);
    end
    i_mem_stall = 1'b0;
    #1;
    check("thaw_bubble", o_bubble, 1);
    tick();
    check("thaw_stall_cnt", o_stall_cnt, 2);
    check("thaw_sel", sel, 0);
    check("thaw_bubble_clear", o_bubble, 0);
    tick();
    check("thaw_mem_op1", sel, 6'b001000);

    // Flush with load-use pending
    id(1, 0, 1, 0, 20, 1, 1);
    tick();
    id(20, 0, 1, 0, 21, 1, 0);
    i_flush = 1'b1;
    #1;
    check("flush_stall", o_stall, 0);
    check("flush_bubble", o_bubble, 0);
    tick();
    i_flush = 1'b0;
    nop();
    check("flush_cnt", o_flush_cnt, 1);
    check("flush_stall_cnt", o_stall_cnt, 2);
    check("flush_sel", sel, 0);

    // Flush during memory stall is not taken
    i_flush = 1'b1;
    i_mem_stall = 1'b1;
    #1;
    tick();
    check("flush_frozen_cnt", o_flush_cnt, 1);
    i_flush = 1'b0;
    i_mem_stall = 1'b0;
    #1;

    // Asynchronous reset in the middle of a load-use
    id(1, 2, 1, 1, 23, 1, 0);
    tick();
    id(23, 0, 1, 0, 22, 1, 1);
    tick();
    check("prerst_sel", sel, 6'b100000);
    id(22, 0, 1, 0, 24, 1, 0);
    check("prerst_stall", o_stall, 1);
    i_rst_n = 1'b0;
    #1;
    check("async_rst_stall", o_stall, 0);
    check("async_rst_bubble", o_bubble, 0);
    check("async_rst_sel", sel, 0);
    check("async_rst_stall_cnt", o_stall_cnt, 0);
    check("async_rst_flush_cnt", o_flush_cnt, 0);
    tick();
    i_rst_n = 1'b1;
    #1;
    check("post_rst_stall", o_stall, 0);
    tick();
    check("post_rst_sel", sel, 0);
    check("post_rst_stall_cnt", o_stall_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
